adder_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational 4-bit adder among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, drives the adder through its dut-side signals (`a`, `b` in, `c` out), captures the sum and returns it to the granted requester with a one-cycle response strobe. It sits between the requesting testbench/agent logic and the shared adder instance.

---
 rtl/adder_arbiter.sv | 142 ++++++++++++++
 tb/tb_adder_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external combinational adder
// among NUM_REQ requesters. One operation is in flight at a time; the
// winner's operands drive the adder for one cycle, the sum is captured and
// returned to that requester with a one-cycle strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for any req_valid; winner sees req_ready this cycle
// S_EXEC | operands held on add_a/add_b, adder output settles
// S_RESP | resp_valid[last_grant] high, resp_sum holds the captured sum
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH:0]             resp_sum,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH:0]             add_c,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [WIDTH-1:0]       add_a_q, add_a_d;
    logic [WIDTH-1:0]       add_b_q, add_b_d;
    logic [WIDTH:0]         resp_sum_q, resp_sum_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic                   busy_q, busy_d;

    logic [WIDTH-1:0]       a_arr [NUM_REQ];
    logic [WIDTH-1:0]       b_arr [NUM_REQ];
    logic [IDX_W-1:0]       winner;
    logic                   win_found;
    int                     idx;

    // Unpack the flat operand buses into per-requester slots.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search, starting one above the previous grant and wrapping.
    always_comb begin
        winner    = last_grant_q;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!win_found && req_valid[IDX_W'(idx)]) begin
                winner    = IDX_W'(idx);
                win_found = 1'b1;
            end
        end
    end

    // Accept pulse only while idle; gated by rst so it reads 0 during reset.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_found && !rst) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        resp_sum_d   = resp_sum_q;
        resp_valid_d = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    add_a_d      = a_arr[winner];
                    add_b_d      = b_arr[winner];
                    last_grant_d = winner;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // Adder output is forwarded unchecked.
                resp_sum_d                 = add_c;
                resp_valid_d[last_grant_q] = 1'b1;
                state_d                    = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_IDX;
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_sum_q   <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            resp_sum_q   <= resp_sum_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign resp_sum   = resp_sum_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: table of single operations, hand-written
// sequences for the multi-cycle corners, then random traffic, all checked
// against a transaction-level model of the arbiter.
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     resp_valid;
    logic [W:0]       resp_sum;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W:0]       add_c;
    logic             busy;

    int tests;
    int fails;

    // Model: pointer of last grant, phase of the op in flight
    // (0 none, 1 operands on adder, 2 response due), held operands, pending sum.
    int m_ptr, m_phase, m_a, m_b, m_id, m_sum;

    // Per-tick observations handed to the sequences.
    int granted;
    int resp_now;
    int obs_sum;

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_sum   (resp_sum),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_c      (add_c),
        .busy       (busy)
    );

    // The shared adder itself.
    assign add_c = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_phase = 0;
        m_a     = 0;
        m_b     = 0;
        m_id    = 0;
        m_sum   = 0;
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int b);
        req_valid[i]      = v;
        req_a[i*W +: W]   = W'(a);
        req_b[i*W +: W]   = W'(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_req_ready"},  32'(req_ready),  0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_add_a"},      32'(add_a),      0);
        check({tag, "_add_b"},      32'(add_b),      0);
        check({tag, "_resp_sum"},   32'(resp_sum),   0);
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, return 1 time unit after it so inputs can be changed.
    task automatic tick();
        logic [N-1:0] er;
        logic [N-1:0] ev;
        int w, wa, wb;
        @(negedge clk);
        if (rst) model_reset();
        w = -1;
        if (!rst && m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy",      32'(busy),      (m_phase != 0) ? 1 : 0);
        check("add_a",     32'(add_a),     m_a);
        check("add_b",     32'(add_b),     m_b);
        ev = '0;
        resp_now = -1;
        if (m_phase == 2) begin
            ev[m_id] = 1'b1;
            resp_now = m_id;
            obs_sum  = int'(resp_sum);
            check("resp_sum", 32'(resp_sum), m_sum);
        end
        check("resp_valid", 32'(resp_valid), 32'(ev));
        wa = 0;
        wb = 0;
        if (w >= 0) begin
            wa = int'(req_a[w*W +: W]);
            wb = int'(req_b[w*W +: W]);
        end
        granted = w;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            m_ptr   = w;
            m_id    = w;
            m_a     = wa;
            m_b     = wb;
            m_sum   = wa + wb;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int req;
        int a;
        int b;
        int sum;
    } vec_t;

    vec_t tbl[8];
    int   order[16];
    int   rids[16];
    int   rsums[16];
    int   gtime[16];
    int   ng, nr, waited, tcount;

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        granted  = -1;
        resp_now = -1;
        obs_sum  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        tbl[0] = '{0,  6,  4, 10};
        tbl[1] = '{1, 15, 15, 30};
        tbl[2] = '{2,  0,  0,  0};
        tbl[3] = '{3, 15,  0, 15};
        tbl[4] = '{0,  9,  8, 17};
        tbl[5] = '{1,  1, 14, 15};
        tbl[6] = '{2,  7,  7, 14};
        tbl[7] = '{3,  8,  8, 16};

        // Reset state.
        #1;
        check_reset_outputs("por");
        tick();
        tick();
        rst = 1'b0;

        // Table of isolated operations: immediate accept, response two cycles later.
        foreach (tbl[t]) begin
            set_req(tbl[t].req, 1'b1, tbl[t].a, tbl[t].b);
            waited = 0;
            do begin
                tick();
                waited++;
            end while (granted != tbl[t].req && waited < 10);
            check("tbl_wait", waited, 1);
            set_req(tbl[t].req, 1'b0, 0, 0);
            tick();
            tick();
            check("tbl_resp_id", resp_now, tbl[t].req);
            check("tbl_sum", obs_sum, tbl[t].sum);
        end

        // All four requesting from reset with operands (i, i+1).
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, i, i + 1);
        ng = 0;
        nr = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (granted >= 0 && ng < 16) begin
                order[ng] = granted;
                gtime[ng] = c;
                ng++;
                set_req(granted, 1'b0, 0, 0);
            end
            if (resp_now >= 0 && nr < 16) begin
                rids[nr]  = resp_now;
                rsums[nr] = obs_sum;
                nr++;
            end
        end
        check("all4_grants", ng, 4);
        check("all4_resps", nr, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                check("all4_order", order[k], k);
                check("all4_spacing", gtime[k], 3 * k);
            end
            if (k < nr) begin
                check("all4_resp_id", rids[k], k);
                check("all4_sum", rsums[k], 2 * k + 1);
            end
        end

        // Fairness: 1 and 3 held valid continuously must alternate.
        set_req(1, 1'b1, 3, 5);
        set_req(3, 1'b1, 12, 9);
        ng = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (granted >= 0 && ng < 16) begin
                order[ng] = granted;
                ng++;
                set_req(granted, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
        end
        check("fair_grants", ng, 8);
        for (int k = 0; k < 8; k++) begin
            if (k < ng) check("fair_order", order[k], (k % 2 == 0) ? 1 : 3);
        end
        req_valid = '0;
        tick();
        tick();
        tick();

        // Reset during EXEC: outputs clear at once, nothing returned,
        // the search restarts at requester 0 so 2 beats 3.
        pulse_reset();
        set_req(2, 1'b1, 9, 5);
        set_req(3, 1'b1, 4, 4);
        tick();
        check("rst_first_grant", granted, 2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midop");
        tick();
        rst = 1'b0;
        tick();
        check("rst_regrant", granted, 2);
        set_req(2, 1'b0, 0, 0);
        tick();
        tick();
        check("rst_resp_id", resp_now, 2);
        check("rst_resp_sum", obs_sum, 14);
        set_req(3, 1'b0, 0, 0);
        tick();
        tick();
        tick();
        tick();

        // Idle: nothing requested for 20 cycles; model holds add_a/add_b.
        req_valid = '0;
        tcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (granted >= 0 || resp_now >= 0) tcount++;
        end
        check("idle_activity", tcount, 0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (i == granted) begin
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end else if (!req_valid[i]) begin
                    set_req(i, ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end else if ($urandom_range(0, 19) == 0) begin
                    set_req(i, 1'b0, 0, 0);
                end
            end
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
